// File: rtl/rv_decode_pkg.sv
// Shared RV decode definitions: immediate format codes and major opcode values.
package rv_decode_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } imm_fmt_t;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction classifier: format code, sign-extended immediate
// and illegal flag for one 32-bit instruction word.
module imm_extract
    import rv_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit SUPPORT_RV64 = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic signed [31:0] imm32;
    imm_fmt_t           fmt_sel;

    always_comb begin
        imm32   = '0;
        fmt_sel = FMT_ILL;
        illegal = 1'b1;
        // Compressed encodings (low bits != 11) fall through as illegal.
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                    fmt_sel = FMT_I;
                    illegal = 1'b0;
                    imm32   = {{20{instr[31]}}, instr[31:20]};
                end
                OPC_OP_IMM_32: begin
                    if (SUPPORT_RV64) begin
                        fmt_sel = FMT_I;
                        illegal = 1'b0;
                        imm32   = {{20{instr[31]}}, instr[31:20]};
                    end
                end
                OPC_STORE: begin
                    fmt_sel = FMT_S;
                    illegal = 1'b0;
                    imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    fmt_sel = FMT_B;
                    illegal = 1'b0;
                    imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt_sel = FMT_U;
                    illegal = 1'b0;
                    imm32   = {instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt_sel = FMT_J;
                    illegal = 1'b0;
                    imm32   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                OPC_OP: begin
                    fmt_sel = FMT_R;
                    illegal = 1'b0;
                end
                OPC_OP_32: begin
                    if (SUPPORT_RV64) begin
                        fmt_sel = FMT_R;
                        illegal = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // imm32[31] always equals instr[31] for non-zero immediates, so widening
    // to 64 bits keeps sign extension anchored on the instruction sign bit.
    assign imm = XLEN'(imm32);
    assign fmt = fmt_sel;

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: imm_extract followed by an output register
// and a one-entry skid register so in_ready depends only on flop state.
module imm_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit SUPPORT_RV64 = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds valid and its data stable until it transfers,
    // and ready never depends combinationally on valid.

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    logic            skid_full;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;

    logic            accept;
    logic            load_out;

    imm_extract #(
        .XLEN         (XLEN),
        .SUPPORT_RV64 (SUPPORT_RV64)
    ) u_extract (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ready = !skid_full;
    assign accept   = in_valid && in_ready;
    assign load_out = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_imm      <= '0;
            out_fmt      <= FMT_R;
            out_illegal  <= 1'b0;
            skid_full    <= 1'b0;
            skid_instr   <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_R;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (load_out) begin
            // A full skid blocks in_ready, so no new input competes with it here.
            if (skid_full) begin
                out_valid   <= 1'b1;
                out_instr   <= skid_instr;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                skid_full   <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_instr   <= in_instr;
                    out_imm     <= dec_imm;
                    out_fmt     <= dec_fmt;
                    out_illegal <= dec_illegal;
                end
            end
        end else if (accept) begin
            skid_full    <= 1'b1;
            skid_instr   <= in_instr;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three configurations share one stimulus stream and
// are checked against a queue-based occupancy model and an arithmetic decoder.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_instr, a_out_imm;
    logic [2:0]  a_out_fmt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [31:0] c_out_instr;
    logic [63:0] c_out_imm;
    logic [2:0]  c_out_fmt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // a: XLEN=32 ; b: XLEN=64 with RV64 opcodes ; c: XLEN=64 without them
    imm_decode_stage #(.XLEN(32), .SUPPORT_RV64(1'b0)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal));
    imm_decode_stage #(.XLEN(64), .SUPPORT_RV64(1'b1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal));
    imm_decode_stage #(.XLEN(64), .SUPPORT_RV64(1'b0)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_instr(c_out_instr), .out_imm(c_out_imm), .out_fmt(c_out_fmt), .out_illegal(c_out_illegal));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder: immediates built by arithmetic shifts of the signed word.
    function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                       output longint imm, output logic [2:0] fmt,
                                       output logic ill);
        longint s;
        s   = longint'($signed(ins));
        imm = 0;
        fmt = 3'd7;
        ill = 1'b1;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'h13, 7'h03, 7'h67, 7'h73: begin fmt = 3'd1; ill = 1'b0; imm = s >>> 20; end
                7'h1B: if (rv64) begin fmt = 3'd1; ill = 1'b0; imm = s >>> 20; end
                7'h23: begin
                    fmt = 3'd2; ill = 1'b0;
                    imm = ((s >>> 25) << 5) | longint'(ins[11:7]);
                end
                7'h63: begin
                    fmt = 3'd3; ill = 1'b0;
                    imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11)
                        | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
                end
                7'h37, 7'h17: begin fmt = 3'd4; ill = 1'b0; imm = s & -64'sd4096; end
                7'h6F: begin
                    fmt = 3'd5; ill = 1'b0;
                    imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12)
                        | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
                end
                7'h33: begin fmt = 3'd0; ill = 1'b0; end
                7'h3B: if (rv64) begin fmt = 3'd0; ill = 1'b0; end
                default: ;
            endcase
        end
    endfunction

    task automatic compare_out(input logic [31:0] ins);
        longint i;
        logic [2:0] f;
        logic il;
        check("a_instr", {32'b0, a_out_instr}, {32'b0, ins});
        ref_decode(ins, 1'b0, i, f, il);
        check("a_imm", {32'b0, a_out_imm}, {32'b0, i[31:0]});
        check("a_fmt", {61'b0, a_out_fmt}, {61'b0, f});
        check("a_illegal", {63'b0, a_out_illegal}, {63'b0, il});
        check("c_imm", c_out_imm, i);
        check("c_fmt", {61'b0, c_out_fmt}, {61'b0, f});
        ref_decode(ins, 1'b1, i, f, il);
        check("b_instr", {32'b0, b_out_instr}, {32'b0, ins});
        check("b_imm", b_out_imm, i);
        check("b_fmt", {61'b0, b_out_fmt}, {61'b0, f});
        check("b_illegal", {63'b0, b_out_illegal}, {63'b0, il});
    endtask

    // One clock: drive at negedge, score the transfer at the edge, check state after.
    task automatic cycle(input logic iv, input logic [31:0] ii, input logic ordy, input logic fl);
        logic acc, fire, stall;
        logic [31:0] s_instr, s_imm;
        logic [2:0]  s_fmt;
        in_valid  = iv;
        in_instr  = ii;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc     = iv && a_in_ready;
        fire    = a_out_valid && ordy;
        stall   = a_out_valid && !ordy && !fl;
        s_instr = a_out_instr;
        s_imm   = a_out_imm;
        s_fmt   = a_out_fmt;
        if (fire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got instr %h expected no entry", a_out_instr);
            end else begin
                compare_out(exp_q[0]);
            end
        end
        @(posedge clk);
        if (fire && exp_q.size() > 0) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(ii);
        @(negedge clk);
        check("out_valid", {63'b0, a_out_valid}, {63'b0, exp_q.size() != 0});
        check("in_ready", {63'b0, a_in_ready}, {63'b0, exp_q.size() < 2});
        if (stall) begin
            check("stall_instr", {32'b0, a_out_instr}, {32'b0, s_instr});
            check("stall_imm", {32'b0, a_out_imm}, {32'b0, s_imm});
            check("stall_fmt", {61'b0, a_out_fmt}, {61'b0, s_fmt});
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[8];
    logic [6:0] opcs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[1] = '{32'h0020A423, 32'h00000008, 3'd2, 1'b0};
        vecs[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0};
        vecs[3] = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0};
        vecs[4] = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 3'd7, 1'b1};
        vecs[6] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
        vecs[7] = '{32'h00000013, 32'h00000000, 3'd1, 1'b0};
        opcs = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
        check("rst_instr", {32'b0, a_out_instr}, 64'd0);
        check("rst_imm", {32'b0, a_out_imm}, 64'd0);
        check("rst_fmt", {61'b0, a_out_fmt}, 64'd0);
        check("rst_illegal", {63'b0, a_out_illegal}, 64'd0);
        check("rst_b_imm", b_out_imm, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back table vectors, one per cycle, 1-cycle latency.
        for (int v = 0; v < 8; v++) begin
            cycle(1'b1, vecs[v].instr, 1'b1, 1'b0);
            check($sformatf("vec%0d_imm", v), {32'b0, a_out_imm}, {32'b0, vecs[v].imm});
            check($sformatf("vec%0d_fmt", v), {61'b0, a_out_fmt}, {61'b0, vecs[v].fmt});
            check($sformatf("vec%0d_ill", v), {63'b0, a_out_illegal}, {63'b0, vecs[v].ill});
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // 64-bit U sign extension and OP-IMM-32 with/without RV64 support.
        cycle(1'b1, 32'h800002B7, 1'b1, 1'b0);
        check("x64_lui_imm", b_out_imm, 64'hFFFFFFFF80000000);
        check("x64_lui_fmt", {61'b0, b_out_fmt}, 64'd4);
        cycle(1'b1, 32'h0010009B, 1'b1, 1'b0);
        check("rv64_addiw_imm", b_out_imm, 64'd1);
        check("rv64_addiw_fmt", {61'b0, b_out_fmt}, 64'd1);
        check("norv64_addiw_ill", {63'b0, c_out_illegal}, 64'd1);
        check("norv64_addiw_fmt", {61'b0, c_out_fmt}, 64'd7);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A, B buffered, C held upstream, then drained in order.
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
        check("bp_in_ready_low", {63'b0, a_in_ready}, 64'd0);
        cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
        check("bp_hold_a", {32'b0, a_out_instr}, 64'h00100093);
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        check("bp_out_b", {32'b0, a_out_instr}, 64'h00200113);
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        check("bp_out_c", {32'b0, a_out_instr}, 64'h00300193);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with two entries held and a simultaneous input.
        cycle(1'b1, 32'h00500293, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600313, 1'b0, 1'b0);
        cycle(1'b1, 32'h00700393, 1'b0, 1'b1);
        check("flush_out_valid", {63'b0, a_out_valid}, 64'd0);
        check("flush_in_ready", {63'b0, a_in_ready}, 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int r;
            ins = $urandom;
            r   = $urandom_range(0, 13);
            if (r < 12) ins[6:0] = opcs[r];
            cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 32'h00800413, 1'b0, 1'b0);
        cycle(1'b1, 32'h00900493, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("areset_out_valid", {63'b0, a_out_valid}, 64'd0);
        check("areset_in_ready", {63'b0, a_in_ready}, 64'd1);
        check("areset_instr", {32'b0, a_out_instr}, 64'd0);
        check("areset_imm", {32'b0, a_out_imm}, 64'd0);
        check("areset_fmt", {61'b0, a_out_fmt}, 64'd0);
        exp_q.delete();
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("areset_no_accept", {63'b0, a_out_valid}, 64'd0);
        reset = 1'b0;
        in_valid = 1'b0;

        cycle(1'b1, 32'h00A00513, 1'b1, 1'b0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
